// File: rtl/vote_tally_tx.sv
// Serial transmitter for a four-candidate vote tally: A5 header, four counts, optional XOR checksum.
// Define VOTE_TX_CHECKSUM_EN to append the checksum byte (6-byte frame); default frame is 5 bytes.
module vote_tally_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cand1_votes,
    input  logic [7:0] cand2_votes,
    input  logic [7:0] cand3_votes,
    input  logic [7:0] cand4_votes,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state_o
);

    // Handshake: send is level-sampled only in IDLE; while busy is high it is ignored.
    // done is a single-cycle pulse on the edge that returns the FSM to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef VOTE_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  snap1_q, snap1_d;
    logic [7:0]  snap2_q, snap2_d;
    logic [7:0]  snap3_q, snap3_d;
    logic [7:0]  snap4_q, snap4_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  cur_byte;
    logic [2:0]  next_bit;
    logic        baud_end;

    always_comb begin
        cur_byte = 8'hA5;
        case (byte_q)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = snap1_q;
            3'd2:    cur_byte = snap2_q;
            3'd3:    cur_byte = snap3_q;
            3'd4:    cur_byte = snap4_q;
`ifdef VOTE_TX_CHECKSUM_EN
            default: cur_byte = 8'hA5 ^ snap1_q ^ snap2_q ^ snap3_q ^ snap4_q;
`else
            default: cur_byte = 8'hFF;
`endif
        endcase
    end

    assign next_bit = bit_q + 3'd1;
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap1_d = snap1_q;
        snap2_d = snap2_q;
        snap3_d = snap3_q;
        snap4_d = snap4_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send) begin
                    snap1_d = cand1_votes;
                    snap2_d = cand2_votes;
                    snap3_d = cand3_votes;
                    snap4_d = cand4_votes;
                    byte_d  = 3'd0;
                    bit_d   = 3'd0;
                    baud_d  = 16'd0;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = next_bit;
                        tx_d  = cur_byte[next_bit];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            snap1_q <= 8'd0;
            snap2_q <= 8'd0;
            snap3_q <= 8'd0;
            snap4_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap1_q <= snap1_d;
            snap2_q <= snap2_d;
            snap3_q <= snap3_d;
            snap4_q <= snap4_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
